// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: FSM state encoding and the packed
// {period, duration} note record used as the FIFO payload.
package note_pkg;

    localparam int NOTE_PERIOD_W = 16;
    localparam int NOTE_DUR_W    = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    typedef logic [NOTE_PERIOD_W+NOTE_DUR_W-1:0] note_t;

    // Build a note record; period occupies the upper half.
    function automatic note_t pack_note(input logic [NOTE_PERIOD_W-1:0] p,
                                        input logic [NOTE_DUR_W-1:0]    d);
        return {p, d};
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Note write path: valid/ready handshake carrying (period, duration), plus
// the synchronous flush that aborts playback and empties the queue.
interface note_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int DUR_WIDTH = 16
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WIDTH-1:0]     wr_period;
    logic [DUR_WIDTH-1:0] wr_duration;
    logic                 flush;

    modport master (output wr_valid, wr_period, wr_duration, flush, input wr_ready);
    modport slave  (input wr_valid, wr_period, wr_duration, flush, output wr_ready);
endinterface

// File: rtl/note_sequencer_fifo.sv
// Synchronous note FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter; clear empties it at once.
module note_fifo
    import note_pkg::*;
#(
    parameter int DATA_W = $bits(note_t),
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign rdata     = mem[rd_ptr_r[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer update; clear wins over push/pop.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push_s) mem[wr_ptr_r[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued (period, duration) notes back-to-back into the square tone
// generator, holding it in reset while idle, during rests and on the first
// cycle of each audible note so every note starts phase-aligned.
module note_sequencer
    import note_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DUR_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int TICK_DIV  = 12000
) (
    input  logic                   clk,
    input  logic                   resetq,
    note_sequencer_if.slave        wr,
    output logic [WIDTH-1:0]       period,
    output logic                   sq_reset,
    output logic                   playing,
    output logic [$clog2(DEPTH):0] level
);
    localparam int NW    = WIDTH + DUR_WIDTH;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NW-1:0]        head_s;
    logic [WIDTH-1:0]     head_period_s;
    logic [DUR_WIDTH-1:0] head_dur_s;
    logic                 full_s, empty_s, push_s, pop_s;
    logic                 wrap_s, last_s;

    state_t               state_r, state_s;
    logic [WIDTH-1:0]     period_r, period_s;
    logic                 sq_reset_r, sq_reset_s;
    logic                 playing_r, playing_s;
    logic [PRE_W-1:0]     presc_r, presc_s;
    logic [DUR_WIDTH-1:0] dur_r, dur_s;

    assign wr.wr_ready = !full_s && !wr.flush;
    assign push_s      = wr.wr_valid && wr.wr_ready;
    assign {head_period_s, head_dur_s} = head_s;
    assign wrap_s      = (presc_r == PRE_W'(TICK_DIV - 1));
    assign last_s      = wrap_s && (dur_r == DUR_WIDTH'(1));

    note_fifo #(.DATA_W(NW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .resetq(resetq),
        .clear (wr.flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({wr.wr_period, wr.wr_duration}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // Next-state logic: flush aborts, otherwise load notes and run the tick counters.
    always_comb begin
        state_s    = state_r;
        period_s   = period_r;
        sq_reset_s = sq_reset_r;
        playing_s  = playing_r;
        presc_s    = presc_r;
        dur_s      = dur_r;
        pop_s      = 1'b0;

        if (wr.flush) begin
            state_s    = ST_IDLE;
            period_s   = '0;
            sq_reset_s = 1'b1;
            playing_s  = 1'b0;
            presc_s    = '0;
            dur_s      = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    period_s   = '0;
                    sq_reset_s = 1'b1;
                    playing_s  = 1'b0;
                    presc_s    = '0;
                    dur_s      = '0;
                    pop_s      = !empty_s;
                    if (!empty_s && (head_dur_s != '0)) begin
                        state_s    = ST_PLAY;
                        period_s   = head_period_s;
                        dur_s      = head_dur_s;
                        playing_s  = 1'b1;
                    end else begin
                        state_s    = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    // Square stays in reset for a whole rest, released otherwise.
                    sq_reset_s = (period_r == '0);
                    presc_s    = wrap_s ? '0 : presc_r + PRE_W'(1);
                    dur_s      = wrap_s ? dur_r - DUR_WIDTH'(1) : dur_r;
                    if (last_s) begin
                        // A zero-length head is popped and dropped; we fall to idle.
                        pop_s = !empty_s;
                        if (!empty_s && (head_dur_s != '0)) begin
                            state_s    = ST_PLAY;
                            period_s   = head_period_s;
                            dur_s      = head_dur_s;
                            presc_s    = '0;
                            sq_reset_s = 1'b1;
                            playing_s  = 1'b1;
                        end else begin
                            state_s    = ST_IDLE;
                            period_s   = '0;
                            sq_reset_s = 1'b1;
                            playing_s  = 1'b0;
                            presc_s    = '0;
                            dur_s      = '0;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    period_s   = '0;
                    sq_reset_s = 1'b1;
                    playing_s  = 1'b0;
                    presc_s    = '0;
                    dur_s      = '0;
                end
            endcase
        end
    end

    // State and output registers; reset parks square in reset with period 0.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_r    <= ST_IDLE;
            period_r   <= '0;
            sq_reset_r <= 1'b1;
            playing_r  <= 1'b0;
            presc_r    <= '0;
            dur_r      <= '0;
        end else begin
            state_r    <= state_s;
            period_r   <= period_s;
            sq_reset_r <= sq_reset_s;
            playing_r  <= playing_s;
            presc_r    <= presc_s;
            dur_r      <= dur_s;
        end
    end

    assign period   = period_r;
    assign sq_reset = sq_reset_r;
    assign playing  = playing_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: per-cycle expected outputs are queued when a note
// is accepted and compared on each falling edge.
module tb_note_sequencer;

    localparam int WIDTH     = 16;
    localparam int DUR_WIDTH = 16;
    localparam int DEPTH     = 4;
    localparam int TICK_DIV  = 4;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic clk    = 1'b0;
    logic resetq = 1'b0;

    always #5 clk = ~clk;

    note_sequencer_if #(.WIDTH(WIDTH), .DUR_WIDTH(DUR_WIDTH)) bus ();

    logic [WIDTH-1:0] period;
    logic             sq_reset;
    logic             playing;
    logic [LW-1:0]    level;

    note_sequencer #(
        .WIDTH(WIDTH), .DUR_WIDTH(DUR_WIDTH), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk     (clk),
        .resetq  (resetq),
        .wr      (bus),
        .period  (period),
        .sq_reset(sq_reset),
        .playing (playing),
        .level   (level)
    );

    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic             sq;
        logic             play;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   waits;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void sb_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.period = '0;
            e.sq     = 1'b1;
            e.play   = 1'b0;
            sb_q.push_back(e);
        end
    endfunction

    // Expected trace of one note: d*TICK_DIV playing cycles, reset on the
    // first cycle or throughout a rest; a zero-length note costs one idle cycle.
    function automatic void sb_note(input logic [WIDTH-1:0] p, input logic [DUR_WIDTH-1:0] d);
        exp_t e;
        if (d == '0) begin
            sb_idle(1);
        end else begin
            for (int i = 0; i < int'(d) * TICK_DIV; i++) begin
                e.period = p;
                e.sq     = (i == 0) || (p == '0);
                e.play   = 1'b1;
                sb_q.push_back(e);
            end
        end
    endfunction

    // Compare outputs against the scoreboard head on every falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("sb_period",   32'(period),   32'(mon_e.period));
            check_eq("sb_sq_reset", 32'(sq_reset), 32'(mon_e.sq));
            check_eq("sb_playing",  32'(playing),  32'(mon_e.play));
        end
    end

    task automatic write_note(input logic [WIDTH-1:0] p, input logic [DUR_WIDTH-1:0] d,
                              input bit lead, input bit track, output int n_wait);
        bit done;
        done   = 1'b0;
        n_wait = 0;
        @(negedge clk);
        bus.wr_valid    = 1'b1;
        bus.wr_period   = p;
        bus.wr_duration = d;
        while (!done && n_wait < 200) begin
            if (bus.wr_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                n_wait++;
                @(negedge clk);
            end
        end
        if (done) begin
            if (track) begin
                if (lead) sb_idle(1);
                sb_note(p, d);
            end
        end else begin
            check_eq("wr_timeout", 32'd0, 32'd1);
        end
        #1 bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_period"},   32'(period),       32'd0);
        check_eq({tag, "_sq_reset"}, 32'(sq_reset),     32'd1);
        check_eq({tag, "_playing"},  32'(playing),      32'd0);
        check_eq({tag, "_level"},    32'(level),        32'd0);
        check_eq({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid    = 1'b0;
        bus.wr_period   = '0;
        bus.wr_duration = '0;
        bus.flush       = 1'b0;
        resetq          = 1'b0;

        // Reset state, during and after release
        repeat (2) @(negedge clk);
        check_idle("rst_in");
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("rst_out");

        // Single note (10,3): 12 playing cycles, one reset pulse, then idle
        write_note(16'd10, 16'd3, 1'b1, 1'b1, waits);
        sb_idle(3);
        wait_drain();

        // Note, rest, note back-to-back
        write_note(16'd5, 16'd1, 1'b1, 1'b1, waits);
        write_note(16'd0, 16'd2, 1'b0, 1'b1, waits);
        write_note(16'd7, 16'd1, 1'b0, 1'b1, waits);
        sb_idle(2);
        wait_drain();

        // Fill the FIFO while a long note plays; fifth write must stall
        write_note(16'd9, 16'd4, 1'b1, 1'b1, waits);
        for (int i = 1; i <= 4; i++) write_note(16'(i), 16'd1, 1'b0, 1'b1, waits);
        @(negedge clk);
        check_eq("full_level",    32'(level),        32'd4);
        check_eq("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        write_note(16'd11, 16'd1, 1'b0, 1'b1, waits);
        check_eq("fifth_stalled", 32'(waits > 0), 32'd1);
        sb_idle(2);
        wait_drain();

        // Zero-duration note skipped between (3,1) and (4,1)
        write_note(16'd3, 16'd1, 1'b1, 1'b1, waits);
        write_note(16'd6, 16'd0, 1'b0, 1'b1, waits);
        write_note(16'd4, 16'd1, 1'b0, 1'b1, waits);
        sb_idle(2);
        wait_drain();

        // Flush mid-note with two queued and a simultaneous write
        write_note(16'd8, 16'd5, 1'b1, 1'b0, waits);
        write_note(16'd1, 16'd1, 1'b0, 1'b0, waits);
        write_note(16'd2, 16'd1, 1'b0, 1'b0, waits);
        repeat (3) @(negedge clk);
        check_eq("pre_flush_playing", 32'(playing), 32'd1);
        check_eq("pre_flush_level",   32'(level),   32'd2);
        check_eq("pre_flush_period",  32'(period),  32'd8);
        bus.flush       = 1'b1;
        bus.wr_valid    = 1'b1;
        bus.wr_period   = 16'd3;
        bus.wr_duration = 16'd1;
        #1 check_eq("flush_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check_idle("flush");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_flush_period", 32'(period), 32'd0);
        end

        // Asynchronous reset mid-note, with a note queued behind it
        write_note(16'd6, 16'd5, 1'b1, 1'b0, waits);
        write_note(16'd2, 16'd1, 1'b0, 1'b0, waits);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_playing", 32'(playing), 32'd1);
        check_eq("pre_rst_period",  32'(period),  32'd6);
        #2 resetq = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        resetq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_playing", 32'(playing), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
